ac_char_rx: RTL and testbench
=============================

Name: ac_char_rx

Overview:
- Receiving end of the character-feed interface of the Aho-Corasick matcher.
- Decodes the two-phase handshake, one character per pair of cycles:
  - arm cycle: INITIALIZE=1, EN=0
  - data cycle: EN=1, INITIALIZE=0, STRING valid
- Each accepted byte goes into a small show-ahead FIFO, which presents characters to the automaton core over a valid/ready interface.
- Also counts accepted characters and flags protocol violations and overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the accepted-character counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- EN  in  1  data phase strobe from the feeder.
- INITIALIZE  in  1  arm phase strobe from the feeder.
- STRING  in  8  character byte; sampled only on a valid data cycle.
- CHAR_OUT  out  8  FIFO head character.
- CHAR_VALID  out  1  FIFO non-empty.
- CHAR_READY  in  1  core consumes the head when CHAR_VALID && CHAR_READY.
- CHAR_CNT  out  CNT_W  number of characters accepted into the FIFO; wraps modulo 2^CNT_W.
- LEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ARMED  out  1  receiver is in the ARMED state.
- PROTO_ERR  out  1  sticky protocol-violation flag.
- OVERFLOW  out  1  sticky dropped-character flag (FIFO full).
- CLR_ERR  in  1  synchronous clear of PROTO_ERR and OVERFLOW.

Behaviour:
- Reset (async, RST=1): state=IDLE; FIFO empty; CHAR_OUT=0; CHAR_VALID=0; LEVEL=0; CHAR_CNT=0; ARMED=0; PROTO_ERR=0; OVERFLOW=0.
- Handshake FSM, two states IDLE and ARMED. Inputs are sampled at each rising edge; the values below are (INITIALIZE, EN):
  - IDLE, (1,0) -> ARMED.
  - IDLE, (0,0) -> IDLE.
  - IDLE, (0,1) -> PROTO_ERR set; character dropped; stay IDLE.
  - ARMED, (1,0) -> stay ARMED (re-arm is legal, no error).
  - ARMED, (0,0) -> stay ARMED (the feeder may stall between phases).
  - ARMED, (0,1) -> push STRING; go to IDLE.
  - Any state, (1,1) -> PROTO_ERR set; nothing pushed; go to IDLE.
- Push acceptance:
  - A push is accepted if LEVEL<DEPTH, or if a pop occurs in the same cycle.
  - If LEVEL==DEPTH and there is no pop: OVERFLOW set, character dropped, CHAR_CNT unchanged, FSM still returns to IDLE.
- CHAR_CNT increments by 1 on each accepted push only; it wraps from 2^CNT_W-1 to 0.
- FIFO behaviour:
  - Show-ahead: CHAR_OUT/CHAR_VALID are registered and always reflect the current head.
  - Latency: a byte pushed at edge N into an empty FIFO gives CHAR_VALID=1 and CHAR_OUT=byte after edge N; there is no fall-through within the same cycle.
  - Pop at an edge where CHAR_VALID && CHAR_READY. CHAR_OUT then advances to the next entry, or CHAR_VALID drops if no entry remains.
  - CHAR_OUT holds its last value when the FIFO is empty.
  - Simultaneous push and pop: LEVEL unchanged. With LEVEL==1, the new byte becomes the head and CHAR_VALID stays 1.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally; LEVEL is kept as a separate counter, so full and empty are unambiguous.
- CHAR_READY while CHAR_VALID=0 is ignored.
- Error flags:
  - CLR_ERR=1 clears both flags at the edge.
  - If a new error event occurs in the same cycle as CLR_ERR, the set wins.
  - The flags never affect data flow.
- RST asserted mid-handshake (ARMED) or with the FIFO holding data: everything returns to reset values immediately; buffered characters are lost.
- No combinational path from any input to any output.

Test Plan:
1. After reset, drive (INIT=1,EN=0), then (0,1) with STRING=0x61 -> one cycle after the data edge: CHAR_VALID=1, CHAR_OUT=0x61, LEVEL=1, CHAR_CNT=1, PROTO_ERR=0.
2. Send 0x61, 0x62, 0x63 with CHAR_READY=0, then hold CHAR_READY=1 -> CHAR_OUT sequence 0x61, 0x62, 0x63 on consecutive cycles, then CHAR_VALID=0, LEVEL=0, CHAR_CNT=3.
3. EN=1 straight from IDLE with STRING=0x41 -> PROTO_ERR=1, LEVEL=0, CHAR_CNT=0. Then pulse CLR_ERR -> PROTO_ERR=0. Then drive (1,1) -> PROTO_ERR=1, ARMED=0.
4. CHAR_READY=0, push 9 characters 0x30-0x38 with DEPTH=8 -> LEVEL=8, OVERFLOW=1, CHAR_CNT=8. Drain -> 0x30..0x37 in order; 0x38 is absent.
5. LEVEL=8, FIFO full, CHAR_READY=1, push 0x5A on the same edge as a pop -> LEVEL stays 8, OVERFLOW=0, 0x5A delivered last.
6. Arm, assert RST for one cycle with LEVEL=3, release, then send a data cycle with no re-arm -> all outputs at reset values after RST. The data cycle then sets PROTO_ERR=1 and pushes nothing.

Source files
------------

// File: rtl/ac_char_rx.sv
// ============================================================================
// ac_char_rx : character-feed receiver for the Aho-Corasick matcher
//   Decodes the arm/data handshake into a show-ahead FIFO, counts accepted
//   characters and raises sticky protocol/overflow flags.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ac_char_rx #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     INITIALIZE,
  input  logic [7:0]               STRING,
  output logic [7:0]               CHAR_OUT,
  output logic                     CHAR_VALID,
  input  logic                     CHAR_READY,
  output logic [CNT_W-1:0]         CHAR_CNT,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     ARMED,
  output logic                     PROTO_ERR,
  output logic                     OVERFLOW,
  input  logic                     CLR_ERR
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   TWO_LVL  = (AW+1)'(2);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   level_next;

  logic data_cyc;
  logic arm_cyc;
  logic both_cyc;
  logic pop;
  logic push_req;
  logic push_ok;
  logic full;
  logic proto_evt;
  logic ovf_evt;

  assign data_cyc   = EN & ~INITIALIZE;
  assign arm_cyc    = INITIALIZE & ~EN;
  assign both_cyc   = EN & INITIALIZE;
  assign pop        = CHAR_VALID & CHAR_READY;
  assign push_req   = (state == S_ARMED) & data_cyc;
  assign full       = (LEVEL == FULL_LVL);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push_ok    = push_req & (~full | pop);
  assign ovf_evt    = push_req & ~push_ok;
  assign proto_evt  = both_cyc | ((state == S_IDLE) & data_cyc);
  assign rd_ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    level_next = LEVEL;
    case ({push_ok, pop})
      2'b10:   level_next = LEVEL + (AW+1)'(1);
      2'b01:   level_next = LEVEL - (AW+1)'(1);
      default: level_next = LEVEL;
    endcase
  end

  // Storage carries no reset; pointers and LEVEL define what is live.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= STRING;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      ARMED      <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      LEVEL      <= '0;
      CHAR_OUT   <= 8'h00;
      CHAR_VALID <= 1'b0;
      CHAR_CNT   <= '0;
      PROTO_ERR  <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (both_cyc) begin
        state <= S_IDLE;
        ARMED <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_cyc) begin
              state <= S_ARMED;
              ARMED <= 1'b1;
            end
          end
          S_ARMED: begin
            if (data_cyc) begin
              state <= S_IDLE;
              ARMED <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            ARMED <= 1'b0;
          end
        endcase
      end

      if (push_ok) begin
        wr_ptr   <= wr_ptr + AW'(1);
        CHAR_CNT <= CHAR_CNT + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      LEVEL      <= level_next;
      CHAR_VALID <= (level_next != '0);

      // Head register: next stored entry, else the incoming byte, else hold.
      if (pop) begin
        if (LEVEL >= TWO_LVL) begin
          CHAR_OUT <= mem[rd_ptr_inc];
        end else if (push_ok) begin
          CHAR_OUT <= STRING;
        end
      end else if ((LEVEL == '0) && push_ok) begin
        CHAR_OUT <= STRING;
      end

      if (proto_evt) begin
        PROTO_ERR <= 1'b1;
      end else if (CLR_ERR) begin
        PROTO_ERR <= 1'b0;
      end
      if (ovf_evt) begin
        OVERFLOW <= 1'b1;
      end else if (CLR_ERR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ac_char_rx.sv
// ============================================================================
// tb_ac_char_rx : directed scoreboard bench for ac_char_rx
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_ac_char_rx;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic              clk;
  logic              rst;
  logic              en;
  logic              initialize;
  logic [7:0]        string_in;
  logic [7:0]        char_out;
  logic              char_valid;
  logic              char_ready;
  logic [CNT_W-1:0]  char_cnt;
  logic [3:0]        level;
  logic              armed;
  logic              proto_err;
  logic              overflow;
  logic              clr_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  ac_char_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .EN         (en),
    .INITIALIZE (initialize),
    .STRING     (string_in),
    .CHAR_OUT   (char_out),
    .CHAR_VALID (char_valid),
    .CHAR_READY (char_ready),
    .CHAR_CNT   (char_cnt),
    .LEVEL      (level),
    .ARMED      (armed),
    .PROTO_ERR  (proto_err),
    .OVERFLOW   (overflow),
    .CLR_ERR    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Monitor: every handshake seen mid-cycle is a pop at the next edge.
  always @(negedge clk) begin
    if (!rst && char_valid && char_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL char_out: got %02h while no character expected", char_out);
      end else begin
        if (char_out !== exp_q[0]) begin
          errors++;
          $display("FAIL char_out: got %02h expected %02h", char_out, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    initialize = 1'b0;
    clr_err = 1'b0;
    char_ready = 1'b0;
    string_in = 8'h00;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " char_out"},   {24'd0, char_out}, 32'h0);
    chk({tag, " char_valid"}, {31'd0, char_valid}, 32'h0);
    chk({tag, " level"},      {28'd0, level}, 32'h0);
    chk({tag, " char_cnt"},   {16'd0, char_cnt}, 32'h0);
    chk({tag, " armed"},      {31'd0, armed}, 32'h0);
    chk({tag, " proto_err"},  {31'd0, proto_err}, 32'h0);
    chk({tag, " overflow"},   {31'd0, overflow}, 32'h0);
  endtask

  // Arm cycle then data cycle; expect=1 queues the byte for the monitor.
  task automatic send(input logic [7:0] b, input bit expect_push);
    initialize = 1'b1;
    en = 1'b0;
    tick();
    initialize = 1'b0;
    en = 1'b1;
    string_in = b;
    if (expect_push) exp_q.push_back(b);
    tick();
    en = 1'b0;
  endtask

  initial begin
    // 1: single character
    do_reset();
    chk_reset_vals("t1 reset");
    send(8'h61, 1'b1);
    chk("t1 char_valid", {31'd0, char_valid}, 32'h1);
    chk("t1 char_out",   {24'd0, char_out}, 32'h61);
    chk("t1 level",      {28'd0, level}, 32'h1);
    chk("t1 char_cnt",   {16'd0, char_cnt}, 32'h1);
    chk("t1 proto_err",  {31'd0, proto_err}, 32'h0);
    char_ready = 1'b1;
    tick();
    chk("t1 drained", {28'd0, level}, 32'h0);

    // 2: three characters, drained back-to-back
    do_reset();
    send(8'h61, 1'b1);
    send(8'h62, 1'b1);
    send(8'h63, 1'b1);
    chk("t2 level", {28'd0, level}, 32'h3);
    char_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t2 char_valid", {31'd0, char_valid}, 32'h0);
    chk("t2 level",      {28'd0, level}, 32'h0);
    chk("t2 char_cnt",   {16'd0, char_cnt}, 32'h3);
    chk("t2 hold out",   {24'd0, char_out}, 32'h63);
    char_ready = 1'b0;

    // 3: protocol violations and clear
    do_reset();
    en = 1'b1;
    string_in = 8'h41;
    tick();
    en = 1'b0;
    chk("t3 proto_err", {31'd0, proto_err}, 32'h1);
    chk("t3 level",     {28'd0, level}, 32'h0);
    chk("t3 char_cnt",  {16'd0, char_cnt}, 32'h0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3 cleared", {31'd0, proto_err}, 32'h0);
    initialize = 1'b1;
    tick();
    chk("t3 armed", {31'd0, armed}, 32'h1);
    en = 1'b1;
    tick();
    en = 1'b0;
    initialize = 1'b0;
    chk("t3 both proto_err", {31'd0, proto_err}, 32'h1);
    chk("t3 both armed",     {31'd0, armed}, 32'h0);
    chk("t3 both level",     {28'd0, level}, 32'h0);

    // 4: overflow on ninth character
    do_reset();
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b1);
    send(8'h38, 1'b0);
    chk("t4 level",     {28'd0, level}, 32'h8);
    chk("t4 overflow",  {31'd0, overflow}, 32'h1);
    chk("t4 char_cnt",  {16'd0, char_cnt}, 32'h8);
    chk("t4 armed",     {31'd0, armed}, 32'h0);
    chk("t4 proto_err", {31'd0, proto_err}, 32'h0);
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    char_ready = 1'b0;
    chk("t4 char_valid", {31'd0, char_valid}, 32'h0);
    chk("t4 queue empty", exp_q.size(), 32'h0);

    // 5: push into a full FIFO on the same edge as a pop
    do_reset();
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 1'b1);
    chk("t5 full level", {28'd0, level}, 32'h8);
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    en = 1'b1;
    string_in = 8'h5A;
    char_ready = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    en = 1'b0;
    char_ready = 1'b0;
    chk("t5 level",    {28'd0, level}, 32'h8);
    chk("t5 overflow", {31'd0, overflow}, 32'h0);
    chk("t5 char_cnt", {16'd0, char_cnt}, 32'h9);
    chk("t5 char_out", {24'd0, char_out}, 32'h41);
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    char_ready = 1'b0;
    chk("t5 char_valid", {31'd0, char_valid}, 32'h0);
    chk("t5 last out",   {24'd0, char_out}, 32'h5A);
    chk("t5 queue empty", exp_q.size(), 32'h0);

    // 6: asynchronous reset while armed with data buffered
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h70 + 8'(i), 1'b0);
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    chk("t6 armed", {31'd0, armed}, 32'h1);
    chk("t6 level", {28'd0, level}, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("t6 async");
    tick();
    rst = 1'b0;
    en = 1'b1;
    string_in = 8'h77;
    tick();
    en = 1'b0;
    chk("t6 proto_err",  {31'd0, proto_err}, 32'h1);
    chk("t6 level",      {28'd0, level}, 32'h0);
    chk("t6 char_cnt",   {16'd0, char_cnt}, 32'h0);
    chk("t6 char_valid", {31'd0, char_valid}, 32'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
